// File: rtl/cmd_queue_if.sv
// Command queue bus: host write side, sequencer load side and status flags.
`timescale 1ns/1ps
interface cmd_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic            cmd_wr;
  logic [321:0]    cmd_in;
  logic            flush;
  logic [63:0]     time_now;
  logic            req_command;
  logic            wr_data;
  logic [321:0]    cmd_out;
  logic            empty;
  logic            full;
  logic [LW-1:0]   level;
  logic            ovf;
  logic [7:0]      drop_cnt;

  modport slave (
    input  cmd_wr, cmd_in, flush, time_now, req_command,
    output wr_data, cmd_out, empty, full, level, ovf, drop_cnt
  );

  modport master (
    output cmd_wr, cmd_in, flush, time_now, req_command,
    input  wr_data, cmd_out, empty, full, level, ovf, drop_cnt
  );
endinterface

// File: rtl/cmd_queue.sv
// Timed command FIFO: pops records in order, drops those whose start time is
// too close to TIME_NOW, and hands the rest to the sequencer one at a time.
`timescale 1ns/1ps
module cmd_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GUARD = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  cmd_queue_if.slave q_if
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [47:0]  TS_RST  = '1;
  localparam logic [321:0] CMD_RST = {128'd0, TS_RST, 146'd0};

  typedef enum logic [1:0] {S_IDLE, S_POP, S_ISSUE, S_BUSY} state_e;

  state_e          state_q, state_d;
  logic            run_q;
  logic            req_q;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic            wr_data_q, wr_data_d;
  logic [321:0]    cmd_out_q, cmd_out_d;
  logic [321:0]    hold_q;
  logic [321:0]    mem_q [DEPTH];

  logic            empty, full, pop, push, done, stale;
  logic [321:0]    head;
  logic [48:0]     limit;
  logic            unused_time_hi;

  assign unused_time_hi = ^q_if.time_now[63:48];

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign head  = mem_q[rptr_q];
  assign done  = q_if.req_command & ~req_q;
  assign limit = {1'b0, q_if.time_now[47:0]} + 49'(GUARD);
  assign stale = ({1'b0, head[193:146]} < limit);
  assign pop   = (state_q == S_POP) & ~q_if.flush;
  // A pop frees a slot in the same edge, so a write to a full queue still lands.
  assign push  = q_if.cmd_wr & ~q_if.flush & (~full | pop);

  // Release is taken through one flop so nothing moves before the second edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      req_q <= 1'b1;
    end else begin
      run_q <= 1'b1;
      req_q <= q_if.req_command;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (q_if.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (q_if.cmd_wr && !push) ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_data_d = 1'b0;
    cmd_out_d = cmd_out_q;
    drop_d    = drop_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_POP;
      S_POP: begin
        if (stale) begin
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wr_data_d = 1'b1;
        cmd_out_d = hold_q;
        state_d   = S_BUSY;
      end
      S_BUSY:  if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (q_if.flush) begin
      state_d   = S_IDLE;
      wr_data_d = 1'b0;
      cmd_out_d = cmd_out_q;
      drop_d    = drop_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      wr_data_q <= 1'b0;
      cmd_out_q <= CMD_RST;
    end else if (run_q) begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      wr_data_q <= wr_data_d;
      cmd_out_q <= cmd_out_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (run_q && push) mem_q[wptr_q] <= q_if.cmd_in;
    if (run_q && pop)  hold_q <= head;
  end

  assign q_if.wr_data  = wr_data_q;
  assign q_if.cmd_out  = cmd_out_q;
  assign q_if.empty    = empty;
  assign q_if.full     = full;
  assign q_if.level    = level_q;
  assign q_if.ovf      = ovf_q;
  assign q_if.drop_cnt = drop_q;
endmodule

// File: tb/tb_cmd_queue.sv
// Bench for cmd_queue: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference of the queue/issue rules.
`timescale 1ns/1ps
module tb_cmd_queue;
  localparam int DEPTH = 8;
  localparam int GUARD = 4;
  localparam logic [47:0]  TS_ONES = '1;
  localparam logic [321:0] RST_REC = {128'd0, TS_ONES, 146'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  cmd_queue_if #(.DEPTH(DEPTH)) bus ();
  cmd_queue #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (.clk_i(clk), .rst_ni(rst_n), .q_if(bus));

  int vectors = 0;
  int errs = 0;
  int ecnt = 0;
  bit chk_en = 0;
  bit tinc = 0;
  logic [63:0] tnow = '0;

  // reference state
  logic [321:0] mq[$];
  bit m_ovf, m_wr, m_idle, m_await, m_gate, m_reqp;
  int m_drop, m_pop_at, m_issue_at;
  logic [321:0] m_out, m_hold;

  task automatic chk(input string nm, input logic [321:0] act, input logic [321:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_wr = 0; m_idle = 1; m_await = 0; m_gate = 1; m_reqp = 1;
    m_drop = 0; m_pop_at = -1; m_issue_at = -1;
    m_out = RST_REC; m_hold = '0;
  endtask

  task automatic model_step();
    bit done, was_full, was_empty, pop_now, stale;
    logic [321:0] rec;
    logic [48:0] lim;
    done = bus.req_command && !m_reqp;
    m_reqp = bus.req_command;
    was_full = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_wr = 0;
    if (bus.flush) begin
      mq.delete(); m_ovf = 0; m_idle = 1; m_await = 0; m_pop_at = -1; m_issue_at = -1;
      return;
    end
    pop_now = (m_pop_at == ecnt);
    if (m_issue_at == ecnt) begin
      m_wr = 1; m_out = m_hold; m_await = 1; m_issue_at = -1;
    end else if (m_await) begin
      if (done) begin m_await = 0; m_idle = 1; end
    end else if (m_idle && !was_empty) begin
      m_idle = 0; m_pop_at = ecnt + 1;
    end
    if (pop_now) begin
      rec = mq.pop_front();
      m_pop_at = -1;
      lim = {1'b0, bus.time_now[47:0]} + 49'(GUARD);
      stale = ({1'b0, rec[193:146]} < lim);
      if (stale) begin
        if (m_drop < 255) m_drop++;
        m_idle = 1;
      end else begin
        m_hold = rec; m_issue_at = ecnt + 1;
      end
    end
    if (bus.cmd_wr) begin
      if (!was_full || pop_now) mq.push_back(bus.cmd_in);
      else m_ovf = 1;
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    ecnt++;
    if (!rst_n) model_reset();
    else if (m_gate) begin
      m_gate = 0; m_reqp = bus.req_command; m_wr = 0;
    end else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("WR_DATA", bus.wr_data, m_wr);
      chk("CMD_OUT", bus.cmd_out, m_out);
      chk("LEVEL", bus.level, mq.size());
      chk("EMPTY", bus.empty, mq.size() == 0);
      chk("FULL", bus.full, mq.size() == DEPTH);
      chk("OVF", bus.ovf, m_ovf);
      chk("DROP_CNT", bus.drop_cnt, m_drop);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [321:0] mk(input logic [47:0] ts);
    logic [321:0] r = '0;
    for (int k = 0; k < 11; k++) r = {r[289:0], 32'($urandom)};
    r[193:146] = ts;
    return r;
  endfunction

  task automatic nxt();
    @(negedge clk);
    #1;
    bus.cmd_wr = 0;
    bus.flush = 0;
    if (tinc) tnow++;
    bus.time_now = tnow;
  endtask

  task automatic idle(input int n);
    repeat (n) nxt();
  endtask

  task automatic put(input logic [47:0] ts, output logic [321:0] rec);
    nxt();
    rec = mk(ts);
    bus.cmd_wr = 1;
    bus.cmd_in = rec;
  endtask

  task automatic wait_wr(output int at, input int lim);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      nxt();
      if (bus.wr_data) begin at = ecnt; break; end
    end
  endtask

  task automatic pulse_done(output int d);
    nxt();
    bus.req_command = 1;
    d = ecnt + 1;
    nxt();
    bus.req_command = 0;
  endtask

  task automatic do_reset();
    nxt();
    #3 rst_n = 0;
    bus.req_command = 0;
    idle(2);
    #3 rst_n = 1;
    idle(3);
  endtask

  initial begin
    logic [321:0] r, recs[3];
    int at, n, d, seen, rdly, rhold;
    logic [47:0] f;
    model_reset();
    bus.cmd_wr = 0; bus.cmd_in = '0; bus.flush = 0; bus.time_now = '0; bus.req_command = 0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_cmd_out", bus.cmd_out, RST_REC);
    #2 rst_n = 1;
    idle(3);

    // single write latency
    tnow = 0; tinc = 0;
    put(48'd1000, r); n = ecnt + 1;
    wait_wr(at, 10);
    chk("latency_first", at, n + 3);
    chk("cmd_out_first", bus.cmd_out, r);
    chk("empty_at_issue", bus.empty, 1);
    pulse_done(d);

    // three records, done after each, then REQ_COMMAND held high
    put(48'd2000, recs[0]); put(48'd2001, recs[1]); put(48'd2002, recs[2]);
    for (int i = 0; i < 3; i++) begin
      wait_wr(at, 20);
      if (i > 0) chk("latency_after_done", at, d + 3);
      chk("order_three", bus.cmd_out, recs[i]);
      if (i < 2) begin nxt(); pulse_done(d); end
    end
    nxt(); bus.req_command = 1;
    idle(10);
    bus.req_command = 0;

    // overflow and flush
    put(48'd3000, r);
    wait_wr(at, 20);
    chk("busy_issue_seen", at > 0, 1);
    for (int i = 0; i < 9; i++) put(48'd3001 + 48'(i), r);
    nxt();
    chk("ovf_level", bus.level, DEPTH);
    chk("ovf_full", bus.full, 1);
    chk("ovf_flag", bus.ovf, 1);
    chk("model_level_full", mq.size(), 8);
    bus.flush = 1;
    nxt();
    chk("flush_level", bus.level, 0);
    chk("flush_ovf", bus.ovf, 0);

    // stale drop and saturation
    do_reset();
    tnow = 5000;
    put(48'd5002, r); put(48'd6000, r);
    wait_wr(at, 20);
    f = bus.cmd_out[193:146];
    chk("stale_drop1", bus.drop_cnt, 1);
    chk("stale_issue_ts", f, 48'd6000);
    pulse_done(d);
    for (int i = 0; i < 300; i++) begin put(48'd10, r); nxt(); end
    idle(10);
    chk("drop_saturate", bus.drop_cnt, 255);
    chk("model_drop_sat", m_drop, 255);

    // write and pop on the same edge while full
    do_reset();
    tnow = 0;
    put(48'd100, r);
    wait_wr(at, 20);
    for (int i = 0; i < DEPTH; i++) put(48'd200 + 48'(i), r);
    nxt();
    chk("pre_pop_level", bus.level, DEPTH);
    bus.req_command = 1;
    nxt(); bus.req_command = 0;
    nxt(); bus.cmd_wr = 1; bus.cmd_in = mk(48'd300);
    nxt();
    chk("wr_pop_level", bus.level, DEPTH);
    chk("wr_pop_ovf", bus.ovf, 0);
    for (int i = 0; i < 12; i++) begin
      wait_wr(at, 30);
      pulse_done(d);
    end

    // reset while BUSY with records queued
    put(48'd400, r);
    wait_wr(at, 20);
    for (int i = 0; i < 4; i++) put(48'd500 + 48'(i), r);
    nxt();
    #3 rst_n = 0;
    #2;
    chk("mid_rst_wr", bus.wr_data, 0);
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_full", bus.full, 0);
    chk("mid_rst_cmd_out", bus.cmd_out, RST_REC);
    idle(2);
    #3 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      nxt();
      if (bus.wr_data) seen++;
      if (i % 7 == 3) bus.req_command = 1; else bus.req_command = 0;
    end
    chk("no_wr_after_rst", seen, 0);

    // random traffic
    bus.req_command = 0;
    do_reset();
    tnow = 64'd100000; tinc = 1;
    rdly = -1; rhold = 0;
    for (int i = 0; i < 4000; i++) begin
      nxt();
      if (bus.wr_data) rdly = $urandom_range(0, 6);
      if (rhold > 0) begin
        rhold--;
        if (rhold == 0) bus.req_command = 0;
      end else if (rdly == 0) begin
        bus.req_command = 1; rhold = $urandom_range(1, 4); rdly = -1;
      end else if (rdly > 0) rdly--;
      else if ($urandom_range(0, 49) == 0) begin
        bus.req_command = 1; rhold = 1;
      end
      if ($urandom_range(0, 99) < 40) begin
        bus.cmd_wr = 1;
        if ($urandom_range(0, 9) == 0)
          bus.cmd_in = mk(tnow[47:0] + 48'd1000);
        else
          bus.cmd_in = mk(tnow[47:0] + 48'($urandom_range(0, 14)));
      end
      if ($urandom_range(0, 99) == 0) bus.flush = 1;
    end
    bus.req_command = 0;
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/cmd_queue.md
CMD_QUEUE -- requirements
Module: cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue depth in command records; SHALL be a power of two, 2..64.
REQ-002 Parameter GUARD, default 4, minimum lead in CLK cycles between TIME_NOW and a record's start time for the record to be issued.
REQ-003 CLK  in  1  system clock, 48 MHz.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 CMD_WR  in  1  one-cycle write strobe for CMD_IN.
REQ-006 CMD_IN  in  322  packed command record, field map per REQ-012.
REQ-007 FLUSH  in  1  synchronous queue clear.
REQ-008 TIME_NOW  in  64  current system time (1/48 us); only [47:0] used.
REQ-009 REQ_COMMAND  in  1  level from the sequencer; high means the current command is finished.
REQ-010 WR_DATA  out  1  one-cycle load strobe to the sequencer; CMD_OUT is valid while it is high.
REQ-011 CMD_OUT  out  322  record presented to the sequencer; same field map as CMD_IN.
REQ-012 Field map, LSB first: Tblank2[31:0], Tblank1[63:32], Interval_Tp[95:64], Interval_Ti[127:96], TYPE_impulse[129:128], N_impuls[145:130], TIME_START[193:146], DDS_delta_rate[225:194], DDS_delta_freq[273:226], DDS_freq[321:274].
REQ-013 EMPTY  out  1  queue holds no records.
REQ-014 FULL  out  1  queue holds DEPTH records.
REQ-015 LEVEL  out  log2(DEPTH)+1  number of stored records.
REQ-016 OVF  out  1  sticky flag; a write was lost to a full queue.
REQ-017 DROP_CNT  out  8  count of records discarded as stale; saturates at 255.

Function
REQ-018 Storage SHALL be a circular FIFO with wrap-around read and write pointers. CMD_WR while not FULL SHALL store CMD_IN; EMPTY, FULL and LEVEL SHALL update on the next clock edge.
REQ-019 CMD_WR while FULL SHALL discard the record, leave the pointers unchanged and set OVF.
REQ-020 A write and an FSM pop in the same cycle SHALL both take effect and leave LEVEL unchanged. When FULL, a write in the same cycle as a pop SHALL be accepted.
REQ-021 FLUSH SHALL empty the queue, clear OVF, and send the FSM to IDLE. FLUSH wins over a write in the same cycle; that write is dropped and OVF is not set. CMD_OUT and DROP_CNT SHALL keep their values.
REQ-022 A rising edge of REQ_COMMAND (REQ_COMMAND=1 with its one-cycle-delayed copy at 0) is a "done" event.
REQ-023 FSM states and transitions:
- IDLE: if not EMPTY, go to POP.
- POP: read the head record into a holding register and increment the read pointer. If head TIME_START < TIME_NOW[47:0]+GUARD, discard the record, increment DROP_CNT and go to IDLE; otherwise go to ISSUE.
- ISSUE: load CMD_OUT from the holding register, pulse WR_DATA=1 for exactly one cycle, go to BUSY.
- BUSY: on a done event go to IDLE; otherwise stay.
REQ-024 The stale compare SHALL be unsigned, computing TIME_NOW[47:0]+GUARD in 49 bits; there is no wrap-around handling.
REQ-025 Latency: with the FSM in IDLE and the queue empty, a write sampled at edge N SHALL give WR_DATA=1 in cycle N+3.
REQ-026 After a done event with the queue non-empty, the next WR_DATA SHALL occur 3 cycles after the done event.
REQ-027 CMD_OUT SHALL change only on the ISSUE cycle and is held stable otherwise.
REQ-028 A done event outside BUSY SHALL be ignored.

Reset
REQ-029 While RESET_N=0 the following SHALL be forced asynchronously: FSM=IDLE, pointers=0, EMPTY=1, FULL=0, LEVEL=0, OVF=0, DROP_CNT=0, WR_DATA=0, REQ_COMMAND edge register=1, CMD_OUT=0 except TIME_START=48'hFFFFFFFFFFFF.
REQ-030 Reset asserted mid-operation SHALL discard all stored and in-flight records without emitting WR_DATA. The first WR_DATA after release requires a new write.
REQ-031 Release SHALL be synchronised to CLK; the first state change is allowed on the second edge after release.

Verification
REQ-032 Reset, TIME_NOW=0, one write with TIME_START=1000 at edge N -> WR_DATA=1 in cycle N+3 only; CMD_OUT=CMD_IN; EMPTY=1 in cycle N+3.
REQ-033 3 writes, REQ_COMMAND pulsed after each WR_DATA -> three WR_DATA pulses in write order, each 3 cycles after the done event; REQ_COMMAND held high produces no extra pulses.
REQ-034 DEPTH=8, 9 writes while BUSY -> FULL=1, LEVEL=8, OVF=1, 9th record never issued; FLUSH -> LEVEL=0, OVF=0.
REQ-035 TIME_NOW=5000, records with TIME_START 5002 then 6000 -> first dropped (DROP_CNT=1), second issued; 300 stale records -> DROP_CNT=255.
REQ-036 Write+pop same cycle at LEVEL=8 -> LEVEL stays 8, OVF=0; pointer wrap after 20 records keeps FIFO order.
REQ-037 RESET_N low in ISSUE or BUSY with 4 records queued -> all outputs at REQ-029 values, no WR_DATA until a new write.
